// File: rtl/ultrasonic_obstacle_if.sv
// Sensor-side signal bundle for the ultrasonic ranger: echo in, trigger and
// measurement results out. The ranger drives through the master modport.
interface ultrasonic_obstacle_if;
    logic        echo;
    logic        trig;
    logic        obs_det;
    logic [22:0] echo_cycles;
    logic        meas_valid;
    logic        timeout;

    modport master (
        input  echo,
        output trig,
        output obs_det,
        output echo_cycles,
        output meas_valid,
        output timeout
    );

    modport slave (
        output echo,
        input  trig,
        input  obs_det,
        input  echo_cycles,
        input  meas_valid,
        input  timeout
    );
endinterface

// File: rtl/ultrasonic_obstacle.sv
// HC-SR04 ranger: periodic trigger, echo width timing, near/far classification
// and a consecutive-agreement filter producing obs_det (1 = clear, 0 = obstacle).
module ultrasonic_obstacle #(
    parameter int TRIG_CYCLES   = 1000,
    parameter int PERIOD_CYCLES = 6000000,
    parameter int ECHO_TIMEOUT  = 3000000,
    parameter int THRESH_CYCLES = 87000,
    parameter int CONFIRM       = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ultrasonic_obstacle_if.master  us
);

    localparam logic [22:0] L_TRIG_M1 = 23'(TRIG_CYCLES - 1);
    localparam logic [22:0] L_PER_M1  = 23'(PERIOD_CYCLES - 1);
    localparam logic [22:0] L_TO      = 23'(ECHO_TIMEOUT);
    localparam logic [22:0] L_TO_M1   = 23'(ECHO_TIMEOUT - 1);
    localparam logic [22:0] L_THRESH  = 23'(THRESH_CYCLES);
    localparam logic [22:0] L_CNT_MAX = '1;
    localparam logic [2:0]  L_CONF    = 3'(CONFIRM);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_echo_m;
    logic        r_echo_s;
    logic        r_echo_prev;
    logic [22:0] r_period;
    logic [22:0] r_cnt;
    logic [22:0] r_echo_cycles;
    logic        r_obs;
    logic        r_timeout;
    logic [2:0]  r_conf;

    logic        w_rise;
    logic        w_to;
    logic        w_upd_width;
    logic [22:0] w_width;
    logic        w_near;
    logic        w_target;

    assign w_rise   = r_echo_s & ~r_echo_prev;
    assign w_near   = ~w_to & (w_width < L_THRESH);
    assign w_target = ~w_near;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_echo_m    <= 1'b0;
            r_echo_s    <= 1'b0;
            r_echo_prev <= 1'b0;
        end else begin
            r_echo_m    <= us.echo;
            r_echo_s    <= r_echo_m;
            r_echo_prev <= r_echo_s;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_to        = 1'b0;
        w_upd_width = 1'b0;
        w_width     = r_cnt;
        case (r_state)
            IDLE:      if (r_period >= L_PER_M1) w_next = TRIG;
            TRIG:      if (r_cnt >= L_TRIG_M1) w_next = WAIT_RISE;
            WAIT_RISE: begin
                // Only a fresh edge counts, so an echo already high on entry is skipped.
                if (w_rise) begin
                    w_next = MEASURE;
                end else if (r_cnt >= L_TO_M1) begin
                    w_next = DONE;
                    w_to   = 1'b1;
                end
            end
            MEASURE: begin
                if (!r_echo_s) begin
                    w_next      = DONE;
                    w_upd_width = 1'b1;
                end else if (r_cnt >= L_TO_M1) begin
                    w_next      = DONE;
                    w_to        = 1'b1;
                    w_upd_width = 1'b1;
                    w_width     = L_TO;
                end
            end
            DONE:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_period <= L_PER_M1;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_next == TRIG) begin
                r_period <= '0;
            end else if (r_period < L_PER_M1) begin
                r_period <= r_period + 23'd1;
            end
            // One shared counter, cleared on every state change.
            if (r_state != w_next) begin
                r_cnt <= '0;
            end else if (r_cnt != L_CNT_MAX) begin
                r_cnt <= r_cnt + 23'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_echo_cycles <= '0;
            r_timeout     <= 1'b0;
            r_obs         <= 1'b0;
            r_conf        <= '0;
        end else if (w_next == DONE) begin
            r_timeout <= w_to;
            if (w_upd_width) r_echo_cycles <= w_width;
            if (w_target == r_obs) begin
                r_conf <= '0;
            end else if (r_conf + 3'd1 >= L_CONF) begin
                r_obs  <= w_target;
                r_conf <= '0;
            end else begin
                r_conf <= r_conf + 3'd1;
            end
        end
    end

    assign us.trig        = (r_state == TRIG);
    assign us.meas_valid  = (r_state == DONE);
    assign us.obs_det     = r_obs;
    assign us.echo_cycles = r_echo_cycles;
    assign us.timeout     = r_timeout;

endmodule

// File: doc/ultrasonic_obstacle.md
# ultrasonic_obstacle

Drives an HC-SR04-style ultrasonic ranger and produces the `obs_det` input consumed by the line-following motor controller. Each measurement fires a trigger pulse, times the echo pulse in clock cycles, and compares the result against a distance threshold. A consecutive-agreement filter sets `obs_det` (1 = path clear, 0 = obstacle, stop), so a single bad echo cannot toggle the rover.

## Interface
- `TRIG_CYCLES`, 1000: trigger pulse width in clocks (10 µs at 100 MHz).
- `PERIOD_CYCLES`, 6000000: minimum spacing between trigger rising edges (60 ms).
- `ECHO_TIMEOUT`, 3000000: maximum wait for the echo rise, and maximum echo width (30 ms).
- `THRESH_CYCLES`, 87000: an echo shorter than this is classified as near (about 15 cm).
- `CONFIRM`, 2: number of consecutive disagreeing measurements needed to flip `obs_det`; range 1–7.
- `clk`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  asynchronous active-low reset.
- `echo`  in  1  sensor echo; asynchronous to `clk`.
- `trig`  out  1  sensor trigger.
- `obs_det`  out  1  1 = clear, 0 = obstacle.
- `echo_cycles`  out  23  width of the last completed echo in clocks, saturating.
- `meas_valid`  out  1  one-cycle pulse when `echo_cycles` and the classification update.
- `timeout`  out  1  set when the last measurement timed out; held until the next `meas_valid`.

## Operation
- `echo` passes through a 2-flop synchronizer. All logic uses the synchronized `echo_s`. A rising edge is `echo_s`=1 with the previous value 0.
- Reset values: `trig`=0, `obs_det`=0, `echo_cycles`=0, `meas_valid`=0, `timeout`=0, FSM in IDLE, period counter preloaded to expired, confirm counter 0.
- FSM states:
  - **IDLE**: go to TRIG when the period counter has expired. The period counter is 23 bits, counts from 0 at each trigger rise, and saturates at `PERIOD_CYCLES`-1.
  - **TRIG**: `trig`=1 for exactly `TRIG_CYCLES` clocks, then go to WAIT_RISE. The wait counter clears on entry.
  - **WAIT_RISE**: wait for an echo rising edge.
    - On the rising edge: clear the width counter and go to MEASURE.
    - If the wait counter reaches `ECHO_TIMEOUT` first: this is a timeout measurement; go to DONE.
    - An echo that is already high on entry is ignored until it falls and rises again.
  - **MEASURE**: the width counter increments every cycle `echo_s`=1.
    - When `echo_s`=0: go to DONE with the width latched.
    - If the width counter reaches `ECHO_TIMEOUT`: this is a timeout measurement; go to DONE with width = `ECHO_TIMEOUT`.
  - **DONE**: one cycle. Pulse `meas_valid`, update `echo_cycles` and `timeout`, apply the filter, return to IDLE.
- Classification:
  - near = not timeout and `echo_cycles` < `THRESH_CYCLES`.
  - A timeout is always classified as far (no echo means nothing in range).
- Filter:
  - Target value: 0 if near, 1 if far.
  - If the target equals the current `obs_det`, the confirm counter clears.
  - Otherwise the confirm counter increments. When it reaches `CONFIRM`, `obs_det` takes the target and the counter clears.
- Arithmetic: all counters are 23 bits, compare against parameters with `>=`, and never wrap.

## Timing
- The first trigger rises on the first `clk` edge after `rst_n` deasserts.
- Trigger rises are spaced exactly `PERIOD_CYCLES` apart when each measurement completes within the period. Otherwise the next trigger fires on the cycle after DONE→IDLE.
- Echo latency is 2 clocks through the synchronizer. A pulse of N clocks at the pin yields `echo_cycles` = N ±1.
- `meas_valid`, `echo_cycles`, `timeout` and `obs_det` all change on the same edge, which is the DONE cycle.
- `obs_det` never changes outside a DONE cycle.
- Reset asserted mid-measurement immediately forces all reset values: `trig` drops asynchronously and `obs_det` goes to 0. A new trigger starts after release.
- An echo edge during TRIG or IDLE is ignored.

## Test plan
- Reset, then release:
  - `trig` rises 1 clock after release, stays high 1000 clocks; `obs_det`=0.
  - The second trigger rise comes 6000000 clocks after the first.
- Echo high for 200000 clocks after each of two triggers:
  - `echo_cycles`≈200000 and `timeout`=0.
  - `obs_det` stays 0 after the first `meas_valid` and rises to 1 at the second.
- From `obs_det`=1, send 50000-clock echoes on two consecutive measurements:
  - `obs_det` falls to 0 exactly at the second `meas_valid`.
- From `obs_det`=1, send one 50000-clock echo followed by one 200000-clock echo:
  - `obs_det` stays 1 throughout and the confirm counter clears.
- No echo at all:
  - `meas_valid` arrives 3000000 clocks after trigger fall with `timeout`=1 and `echo_cycles` unchanged; this counts toward clear.
  - Echo held high indefinitely: `echo_cycles`=3000000 and `timeout`=1.
- Assert `rst_n`=0 midway through a 100000-clock echo:
  - All outputs are at their reset values in the same cycle.
  - After release, the next trigger fires on the first edge, with no spurious `meas_valid`.
